// File: rtl/pc_sequencer_if.sv
// Fetch command/status bundle between decode/compare logic and the PC sequencer.
// master issues commands and observes PC/status; slave is the sequencer.
interface pc_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              stall;
    logic [1:0]        fetch_control;
    logic              jump_uncond;
    logic              cond_true;
    logic              link;
    logic [ADDR_W-1:0] jump_offset;
    logic              resume;
    logic [ADDR_W-1:0] instr_rd_addr;
    logic [ADDR_W-1:0] pcval;
    logic              halted;
    logic              ras_empty;
    logic              ras_full;
    logic              fault;

    modport master (
        output stall, fetch_control, jump_uncond, cond_true, link, jump_offset, resume,
        input  instr_rd_addr, pcval, halted, ras_empty, ras_full, fault
    );

    modport slave (
        input  stall, fetch_control, jump_uncond, cond_true, link, jump_offset, resume,
        output instr_rd_addr, pcval, halted, ras_empty, ras_full, fault
    );
endinterface

// File: rtl/pc_sequencer.sv
// PC sequencer with return-address stack; PC_SEQ_TRAP_EN redirects RAS faults to TRAP_VEC.
// Latency: one cycle, a command sampled at edge N is visible on instr_rd_addr after edge N.
// Backpressure: stall holds PC, pcval and RAS and drops the command; HALT ignores commands.
module pc_sequencer #(
    parameter int                ADDR_W    = 10,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter logic [ADDR_W-1:0] TRAP_VEC  = {ADDR_W{1'b1}}
) (
    input  logic           clk,
    input  logic           reset,
    pc_sequencer_if.slave  bus
);
    localparam int               PTR_W    = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int               CNT_W    = $clog2(RAS_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(RAS_DEPTH);
    localparam logic [0:0]       ST_RUN   = 1'b0;
    localparam logic [0:0]       ST_HALT  = 1'b1;
`ifdef PC_SEQ_TRAP_EN
    localparam bit               TRAP_EN  = 1'b1;
`else
    localparam bit               TRAP_EN  = 1'b0;
`endif

    logic [0:0]        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pcval_q, pcval_d;
    logic              fault_q, fault_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
    logic [ADDR_W-1:0] ras_d [RAS_DEPTH];
    // sp points at the next free slot; when full that slot holds the oldest entry.
    logic [PTR_W-1:0]  sp_q, sp_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ADDR_W-1:0] pc_inc, pc_tgt;
    logic [PTR_W-1:0]  sp_inc, sp_dec;
    logic              ras_empty, ras_full, taken;

    assign pc_inc    = pc_q + ADDR_W'(1);
    assign pc_tgt    = pc_q + bus.jump_offset;
    assign sp_inc    = (sp_q == PTR_LAST) ? '0 : sp_q + PTR_W'(1);
    assign sp_dec    = (sp_q == '0) ? PTR_LAST : sp_q - PTR_W'(1);
    assign ras_empty = (cnt_q == '0);
    assign ras_full  = (cnt_q == CNT_FULL);
    assign taken     = bus.jump_uncond | bus.cond_true;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        ras_d   = ras_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        if (state_q == ST_HALT) begin
            if (bus.resume) begin
                pc_d    = pc_inc;
                state_d = ST_RUN;
            end
        end else if (!bus.stall) begin
            case (bus.fetch_control)
                2'b00: pc_d = pc_inc;
                2'b01: begin
                    if (!taken) begin
                        pc_d = pc_inc;
                    end else begin
                        pc_d = pc_tgt;
                        if (bus.link) begin
                            if (ras_full) fault_d = 1'b1;
                            if (ras_full && TRAP_EN) begin
                                pc_d = TRAP_VEC;
                            end else begin
                                ras_d[sp_q] = pc_inc;
                                sp_d        = sp_inc;
                                if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
                            end
                        end
                    end
                end
                2'b10: begin
                    if (!ras_empty) begin
                        pc_d  = ras_q[sp_dec];
                        sp_d  = sp_dec;
                        cnt_d = cnt_q - CNT_W'(1);
                    end else begin
                        fault_d = 1'b1;
                        pc_d    = TRAP_EN ? TRAP_VEC : pc_inc;
                    end
                end
                default: state_d = ST_HALT;
            endcase
        end
    end

    // pcval tracks the address that was on the bus before each PC change.
    assign pcval_d = (pc_d != pc_q) ? pc_q : pcval_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_VEC;
            pcval_q <= RESET_VEC;
            fault_q <= 1'b0;
            sp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pcval_q <= pcval_d;
            fault_q <= fault_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stack contents need no reset: the entry count gates every read.
    always_ff @(posedge clk) begin
        ras_q <= ras_d;
    end

    assign bus.instr_rd_addr = pc_q;
    assign bus.pcval         = pcval_q;
    assign bus.halted        = (state_q == ST_HALT);
    assign bus.ras_empty     = ras_empty;
    assign bus.ras_full      = ras_full;
    assign bus.fault         = fault_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (ADDR_W=10, RAS_DEPTH=4, RESET_VEC=0, TRAP_VEC=0x3FF).
module tb_pc_sequencer;
    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pc_sequencer_if #(.ADDR_W(10)) bus ();

    pc_sequencer #(
        .ADDR_W(10), .RAS_DEPTH(4), .RESET_VEC(10'h000), .TRAP_VEC(10'h3FF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    function automatic logic [3:0] flags();
        return {bus.halted, bus.ras_empty, bus.ras_full, bus.fault};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input logic [1:0] fc, input logic unc, input logic cnd,
                       input logic lnk, input logic [9:0] off);
        bus.fetch_control = fc;
        bus.jump_uncond   = unc;
        bus.cond_true     = cnd;
        bus.link          = lnk;
        bus.jump_offset   = off;
    endtask

    task automatic goto(input logic [9:0] from, input logic [9:0] to);
        cmd(2'b01, 1'b1, 1'b0, 1'b0, 10'(to - from));
        tick();
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic do_reset();
        bus.stall  = 1'b0;
        bus.resume = 1'b0;
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.instr_rd_addr !== 10'h000) begin failures++; $display("FAIL reset_pc got=%h exp=000", bus.instr_rd_addr); end
        checks++; if (bus.pcval !== 10'h000) begin failures++; $display("FAIL reset_pcval got=%h exp=000", bus.pcval); end
        checks++; if (flags() !== 4'b0100) begin failures++; $display("FAIL reset_flags got=%b exp=0100", flags()); end
    endtask

    task automatic test_sequential();
        for (int i = 1; i <= 5; i++) begin
            tick();
            checks++; if (bus.instr_rd_addr !== 10'(i)) begin failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.instr_rd_addr, 10'(i)); end
            checks++; if (bus.pcval !== 10'(i - 1)) begin failures++; $display("FAIL seq_pcval[%0d] got=%h exp=%h", i, bus.pcval, 10'(i - 1)); end
        end
        checks++; if (flags() !== 4'b0100) begin failures++; $display("FAIL seq_flags got=%b exp=0100", flags()); end
    endtask

    task automatic test_wrap();
        goto(10'h005, 10'h3FE);
        checks++; if (bus.instr_rd_addr !== 10'h3FE) begin failures++; $display("FAIL wrap_goto got=%h exp=3fe", bus.instr_rd_addr); end
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h3FF) begin failures++; $display("FAIL wrap_3ff got=%h exp=3ff", bus.instr_rd_addr); end
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h000) begin failures++; $display("FAIL wrap_000 got=%h exp=000", bus.instr_rd_addr); end
        checks++; if (bus.pcval !== 10'h3FF) begin failures++; $display("FAIL wrap_pcval got=%h exp=3ff", bus.pcval); end
    endtask

    task automatic test_branch();
        goto(10'h000, 10'h010);
        cmd(2'b01, 1'b0, 1'b0, 1'b0, 10'h3FC);
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h011) begin failures++; $display("FAIL br_not_taken got=%h exp=011", bus.instr_rd_addr); end
        cmd(2'b01, 1'b0, 1'b1, 1'b0, 10'h3FC);
        bus.stall = 1'b1;
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h011) begin failures++; $display("FAIL br_stall_pc got=%h exp=011", bus.instr_rd_addr); end
        checks++; if (bus.pcval !== 10'h010) begin failures++; $display("FAIL br_stall_pcval got=%h exp=010", bus.pcval); end
        bus.stall = 1'b0;
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h00D) begin failures++; $display("FAIL br_taken got=%h exp=00d", bus.instr_rd_addr); end
        checks++; if (bus.pcval !== 10'h011) begin failures++; $display("FAIL br_taken_pcval got=%h exp=011", bus.pcval); end
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic test_calls();
        logic [9:0] exp_ret [4];
        logic [9:0] exp_last;
        logic [3:0] exp_f;
`ifdef PC_SEQ_TRAP_EN
        exp_last = 10'h3FF;
        exp_ret  = '{10'h051, 10'h041, 10'h031, 10'h021};
`else
        exp_last = 10'h070;
        exp_ret  = '{10'h061, 10'h051, 10'h041, 10'h031};
`endif
        goto(10'h00D, 10'h020);
        for (int i = 0; i < 5; i++) begin
            cmd(2'b01, 1'b1, 1'b0, 1'b1, 10'h010);
            tick();
            exp_f = {1'b0, 1'b0, (i >= 3), (i == 4)};
            checks++; if (flags() !== exp_f) begin failures++; $display("FAIL call_flags[%0d] got=%b exp=%b", i, flags(), exp_f); end
        end
        checks++; if (bus.instr_rd_addr !== exp_last) begin failures++; $display("FAIL call_overflow_pc got=%h exp=%h", bus.instr_rd_addr, exp_last); end
        for (int j = 0; j < 4; j++) begin
            cmd(2'b10, 1'b0, 1'b0, 1'b0, 10'h000);
            tick();
            checks++; if (bus.instr_rd_addr !== exp_ret[j]) begin failures++; $display("FAIL ret_pc[%0d] got=%h exp=%h", j, bus.instr_rd_addr, exp_ret[j]); end
        end
        checks++; if (flags() !== 4'b0101) begin failures++; $display("FAIL ret_flags got=%b exp=0101", flags()); end
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic test_underflow();
        logic [9:0] exp_pc;
`ifdef PC_SEQ_TRAP_EN
        exp_pc = 10'h3FF;
`else
        exp_pc = 10'h101;
`endif
        do_reset();
        goto(10'h000, 10'h100);
        checks++; if (bus.fault !== 1'b0) begin failures++; $display("FAIL uf_pre_fault got=%b exp=0", bus.fault); end
        cmd(2'b10, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        checks++; if (bus.instr_rd_addr !== exp_pc) begin failures++; $display("FAIL uf_pc got=%h exp=%h", bus.instr_rd_addr, exp_pc); end
        checks++; if (flags() !== 4'b0101) begin failures++; $display("FAIL uf_flags got=%b exp=0101", flags()); end
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    task automatic test_halt();
        logic [1:0] fc_tab [3] = '{2'b00, 2'b01, 2'b10};
        logic       st_tab [3] = '{1'b1, 1'b0, 1'b1};
        do_reset();
        goto(10'h000, 10'h080);
        cmd(2'b11, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h080) begin failures++; $display("FAIL halt_pc got=%h exp=080", bus.instr_rd_addr); end
        checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_rise got=%b exp=1", bus.halted); end
        for (int i = 0; i < 3; i++) begin
            cmd(fc_tab[i], 1'b1, 1'b1, 1'b1, 10'h020);
            bus.stall = st_tab[i];
            tick();
            checks++; if (bus.instr_rd_addr !== 10'h080) begin failures++; $display("FAIL halt_hold[%0d] got=%h exp=080", i, bus.instr_rd_addr); end
            checks++; if (flags() !== 4'b1100) begin failures++; $display("FAIL halt_flags[%0d] got=%b exp=1100", i, flags()); end
        end
        bus.stall = 1'b0;
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
        bus.resume = 1'b1;
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h081) begin failures++; $display("FAIL resume_pc got=%h exp=081", bus.instr_rd_addr); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL resume_halted got=%b exp=0", bus.halted); end
        checks++; if (bus.pcval !== 10'h080) begin failures++; $display("FAIL resume_pcval got=%h exp=080", bus.pcval); end
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h082) begin failures++; $display("FAIL resume_in_run got=%h exp=082", bus.instr_rd_addr); end
        bus.resume = 1'b0;
        cmd(2'b11, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        checks++; if (bus.halted !== 1'b1) begin failures++; $display("FAIL halt_again got=%b exp=1", bus.halted); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
        checks++; if (bus.instr_rd_addr !== 10'h000) begin failures++; $display("FAIL halt_reset_pc got=%h exp=000", bus.instr_rd_addr); end
        checks++; if (bus.halted !== 1'b0) begin failures++; $display("FAIL halt_reset_halted got=%b exp=0", bus.halted); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] fc_tab  [5] = '{2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
        logic [9:0] off_tab [5] = '{10'h040, 10'h000, 10'h010, 10'h010, 10'h000};
        logic [9:0] pc_tab  [5] = '{10'h240, 10'h201, 10'h211, 10'h221, 10'h212};
        do_reset();
        goto(10'h000, 10'h200);
        for (int i = 0; i < 5; i++) begin
            cmd(fc_tab[i], 1'b1, 1'b0, 1'b1, off_tab[i]);
            tick();
            checks++; if (bus.instr_rd_addr !== pc_tab[i]) begin failures++; $display("FAIL b2b_pc[%0d] got=%h exp=%h", i, bus.instr_rd_addr, pc_tab[i]); end
        end
        cmd(2'b10, 1'b0, 1'b0, 1'b0, 10'h000);
        tick();
        checks++; if (bus.instr_rd_addr !== 10'h202) begin failures++; $display("FAIL b2b_last_ret got=%h exp=202", bus.instr_rd_addr); end
        checks++; if (flags() !== 4'b0100) begin failures++; $display("FAIL b2b_flags got=%b exp=0100", flags()); end
        cmd(2'b00, 1'b0, 1'b0, 1'b0, 10'h000);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_wrap();
        test_branch();
        test_calls();
        test_underflow();
        test_halt();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
